// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampled UART receiver, LSB first, 1 start bit,
// DATA_WIDTH data bits, optional parity bit, 1 stop bit.
// Optional parity support is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_in,
  input  logic                      rx_enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
`ifdef UART_RX_PARITY_EN
  input  logic                      par_type,
  output logic                      par_error,
`endif
  output logic [DATA_WIDTH-1:0]     p_data,
  output logic                      data_valid,
  output logic                      framing_error,
  output logic                      busy
);

  localparam int PW  = PRESCALE_WIDTH;
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, rx_s_q;
  logic [PW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [2:0]            samp_q, samp_d;
  logic                  bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  dv_q, dv_d;
  logic                  fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
  logic                  ptype_q, ptype_d;
  logic                  perr_q, perr_d;
  logic                  pe_q, pe_d;
`endif

  logic [PW-1:0] half;
  logic          bit_end;
  logic          presc_legal;

  assign half        = presc_q >> 1;
  assign bit_end     = (cnt_q == presc_q - PW'(1));
  assign presc_legal = (prescale == PW'(8)) || (prescale == PW'(16)) ||
                       (prescale == PW'(32));

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rx_s_q  <= sync1_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, bit timing, majority vote, shift register and output pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    pdata_d = pdata_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    ptype_d = ptype_q;
    perr_d  = perr_q;
    pe_d    = 1'b0;
`endif

    // Three samples around mid-bit, vote registered two counts later.
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + PW'(1);
      if (cnt_q == half - PW'(1)) samp_d[0] = rx_s_q;
      if (cnt_q == half)          samp_d[1] = rx_s_q;
      if (cnt_q == half + PW'(1)) samp_d[2] = rx_s_q;
      if (cnt_q == half + PW'(2)) bit_d     = maj3(samp_q);
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_enable && !rx_s_q) begin
          state_d = S_START;
          presc_d = presc_legal ? prescale : PW'(8);
`ifdef UART_RX_PARITY_EN
          ptype_d = par_type;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          if (bit_q) state_d = S_IDLE;  // start bit did not hold: glitch
          else begin
            state_d = S_DATA;
            bcnt_d  = '0;
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {bit_q, shift_q[DATA_WIDTH-1:1]};
          bcnt_d  = bcnt_q + BCW'(1);
          if (bcnt_q == BCW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          perr_d  = bit_q ^ (^shift_q) ^ ptype_q;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (!bit_q) fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (perr_q) pe_d = 1'b1;
          if (bit_q && !perr_q) begin
`else
          if (bit_q) begin
`endif
            pdata_d = shift_q;
            dv_d    = 1'b1;
          end
          // Next start bit may follow the stop bit directly.
          state_d = (rx_enable && !rx_s_q) ? S_START : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disabling the receiver drops any frame in progress silently.
    if (state_q != S_IDLE && !rx_enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      pdata_d = pdata_q;
      dv_d    = 1'b0;
      fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_d    = 1'b0;
`endif
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      presc_q <= PW'(8);
      samp_q  <= '0;
      bit_q   <= 1'b0;
      shift_q <= '0;
      bcnt_q  <= '0;
      pdata_q <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      ptype_q <= 1'b0;
      perr_q  <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      pdata_q <= pdata_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      ptype_q <= ptype_d;
      perr_q  <= perr_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign p_data        = pdata_q;
  assign data_valid    = dv_q;
  assign framing_error = fe_q;
  assign busy          = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign par_error     = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed frames from the test
// plan plus randomized frames, checked against a frame-level reference model.
module tb_uart_rx_deserializer;

  localparam int DW = 8;
  localparam int PW = 6;
`ifdef UART_RX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic          rx_enable;
  logic [PW-1:0] prescale;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          framing_error;
  logic          busy;
`ifdef UART_RX_PARITY_EN
  logic          par_type;
  logic          par_error;
  logic          ptype;     // model's parity type for the current frame
  logic          par_flip;  // send a wrong parity bit when set
  int            pe_n;
`endif

  uart_rx_deserializer #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .rx_enable(rx_enable),
    .prescale(prescale),
`ifdef UART_RX_PARITY_EN
    .par_type(par_type), .par_error(par_error),
`endif
    .p_data(p_data), .data_valid(data_valid),
    .framing_error(framing_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            fe_n, busy_n;
  logic          last_busy;
  int            dv_q[$];
  logic [DW-1:0] dv_v[$];
  logic [DW-1:0] exp_pdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    dv_q.delete();
    dv_v.delete();
    fe_n   = 0;
    busy_n = 0;
`ifdef UART_RX_PARITY_EN
    pe_n   = 0;
`endif
  endtask

  // One clock: sample the outputs of the last edge, then drive the line.
  task automatic step(input logic v);
    @(posedge clk);
    #1;
    cyc++;
    if (data_valid) begin
      dv_q.push_back(cyc);
      dv_v.push_back(p_data);
    end
    if (framing_error) fe_n++;
`ifdef UART_RX_PARITY_EN
    if (par_error) pe_n++;
`endif
    if (busy) busy_n++;
    last_busy = busy;
    if (data_valid || framing_error)
      chk("dv_fe_exclusive", 32'(data_valid & framing_error), 0);
    rx_in = v;
  endtask

  // Drive one frame, each bit held p cycles. abort_b / rst_b name the line bit
  // during which rx_enable drops or rst rises (-1 for none).
  task automatic frame(input logic [DW-1:0] d, input int p, input logic [PW-1:0] pre,
                       input logic stop_b, input int abort_b, input int rst_b,
                       input int tail, output int s);
    logic [NB-1:0] line;
    line         = '0;
    line[DW:1]   = d;
    line[NB-1]   = stop_b;
`ifdef UART_RX_PARITY_EN
    line[NB-2]   = (^d) ^ ptype ^ par_flip;
    par_type     = ptype;
`endif
    prescale = pre;
    s = cyc + 1;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < p; c++) begin
        step(line[b]);
        // Settings are latched at frame start; later changes must not matter.
        if (b == 1 && c == 0) begin
          prescale = PW'($urandom);
`ifdef UART_RX_PARITY_EN
          par_type = 1'($urandom);
`endif
        end
        if (b == abort_b && c == p / 2) begin
          rx_enable = 1'b0;
          step(line[b]);
          chk("abort_busy_next_cycle", 32'(last_busy), 0);
        end
        if (b == rst_b && c == p / 2) begin
          rst = 1'b1;
          #1;
          chk("rst_p_data", 32'(p_data), 0);
          chk("rst_data_valid", 32'(data_valid), 0);
          chk("rst_framing_error", 32'(framing_error), 0);
          chk("rst_busy", 32'(busy), 0);
`ifdef UART_RX_PARITY_EN
          chk("rst_par_error", 32'(par_error), 0);
`endif
          exp_pdata = '0;
        end
      end
    end
    rst = 1'b0;
    for (int i = 0; i < tail; i++) step(1'b1);
    rx_enable = 1'b1;
  endtask

  // Frame-level model: good stop (and parity) -> one data_valid with d, rising
  // 2 + NB*P edges after the first edge that captures the falling start edge
  // (edge s+1); bad stop -> one framing_error and p_data unchanged.
  task automatic check_result(input string tag, input int s, input int p,
                              input logic [DW-1:0] d, input logic stop_b);
    logic par_ok;
    int   exp_dv;
    par_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_ok = !par_flip;
    chk({tag, "_par_error_count"}, 32'(pe_n), par_ok ? 0 : 1);
`endif
    exp_dv = (stop_b && par_ok) ? 1 : 0;
    chk({tag, "_dv_count"}, 32'(dv_q.size()), 32'(exp_dv));
    chk({tag, "_fe_count"}, 32'(fe_n), stop_b ? 0 : 1);
    if (exp_dv == 1 && dv_q.size() == 1) begin
      chk({tag, "_dv_latency"}, 32'(dv_q[0] - s), 32'(1 + 2 + NB * p));
      chk({tag, "_dv_value"}, 32'(dv_v[0]), 32'(d));
    end
    if (exp_dv == 1) exp_pdata = d;
    chk({tag, "_p_data"}, 32'(p_data), 32'(exp_pdata));
    chk({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  initial begin
    int s, s2, p;
    logic [DW-1:0] d;
    logic stop_b;
    int psel[3];
    psel = '{8, 16, 32};

    rst = 1'b1; rx_in = 1'b1; rx_enable = 1'b1; prescale = PW'(8);
    exp_pdata = '0;
`ifdef UART_RX_PARITY_EN
    par_type = 1'b0; ptype = 1'b0; par_flip = 1'b0;
`endif
    clr();
    repeat (3) step(1'b1);
    chk("reset_p_data", 32'(p_data), 0);
    chk("reset_data_valid", 32'(data_valid), 0);
    chk("reset_framing_error", 32'(framing_error), 0);
    chk("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (3) step(1'b1);

    // 0xA5 at prescale 8: pulse 82 edges after the start edge is captured.
    clr();
    frame(8'hA5, 8, PW'(8), 1'b1, -1, -1, 12, s);
    check_result("a5_p8", s, 8, 8'hA5, 1'b1);

    // Two-cycle glitch at prescale 16: busy for one bit time, nothing else.
    clr();
    prescale = PW'(16);
    step(1'b0); step(1'b0);
    repeat (30) step(1'b1);
    chk("glitch_busy_cycles", 32'(busy_n), 16);
    chk("glitch_dv_count", 32'(dv_q.size()), 0);
    chk("glitch_fe_count", 32'(fe_n), 0);
    chk("glitch_p_data", 32'(p_data), 32'(exp_pdata));

    // Framing error: stop bit low.
    clr();
    frame(8'h3C, 8, PW'(8), 1'b0, -1, -1, 12, s);
    check_result("framing_3c", s, 8, 8'h3C, 1'b0);

    // Back-to-back 0x00, 0xFF at prescale 32 with no idle gap.
    clr();
    frame(8'h00, 32, PW'(32), 1'b1, -1, -1, 0, s);
    frame(8'hFF, 32, PW'(32), 1'b1, -1, -1, 12, s2);
    chk("b2b_dv_count", 32'(dv_q.size()), 2);
    if (dv_q.size() == 2) begin
      chk("b2b_first_latency", 32'(dv_q[0] - s), 32'(3 + NB * 32));
      chk("b2b_spacing", 32'(dv_q[1] - dv_q[0]), 32'(NB * 32));
      chk("b2b_first_value", 32'(dv_v[0]), 32'h00);
      chk("b2b_second_value", 32'(dv_v[1]), 32'hFF);
    end
    chk("b2b_fe_count", 32'(fe_n), 0);
    exp_pdata = 8'hFF;

    // rx_enable dropped during data bit 4 (line bit 5).
    clr();
    frame(8'h96, 8, PW'(8), 1'b1, 5, -1, 12, s);
    chk("abort_dv_count", 32'(dv_q.size()), 0);
    chk("abort_fe_count", 32'(fe_n), 0);
    chk("abort_p_data", 32'(p_data), 32'(exp_pdata));
    chk("abort_busy_after", 32'(busy), 0);

    // Reset mid-frame, then a clean 0x5A.
    clr();
    frame(8'hC3, 8, PW'(8), 1'b1, -1, 4, 12, s);
    chk("rstmid_dv_count", 32'(dv_q.size()), 0);
    chk("rstmid_p_data", 32'(p_data), 0);
    clr();
    frame(8'h5A, 8, PW'(8), 1'b1, -1, -1, 12, s);
    check_result("after_rst_5a", s, 8, 8'h5A, 1'b1);

    // Illegal prescale is treated as 8.
    clr();
    d = DW'($urandom);
    frame(d, 8, PW'(5), 1'b1, -1, -1, 12, s);
    check_result("illegal_presc", s, 8, d, 1'b1);

    // Randomized frames.
    for (int n = 0; n < 12; n++) begin
      clr();
      p      = psel[$urandom_range(0, 2)];
      d      = DW'($urandom);
      stop_b = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      ptype    = 1'($urandom);
      par_flip = ($urandom_range(0, 3) == 0);
`endif
      frame(d, p, PW'(p), stop_b, -1, -1, 8 + int'($urandom_range(0, 20)), s);
      check_result($sformatf("rand%0d", n), s, p, d, stop_b);
    end

`ifdef UART_RX_PARITY_EN
    // Even parity, 0xA5 with parity bit 1 (wrong), then 0 (right).
    ptype = 1'b0;
    clr();
    par_flip = 1'b1;
    frame(8'hA5, 8, PW'(8), 1'b1, -1, -1, 12, s);
    check_result("par_bad_a5", s, 8, 8'hA5, 1'b1);
    clr();
    par_flip = 1'b0;
    frame(8'hA5, 8, PW'(8), 1'b1, -1, -1, 12, s);
    check_result("par_good_a5", s, 8, 8'hA5, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
